// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo encoder input interleaver: default geometry,
// QPP coefficients, the read-side FSM state type and a closed-form QPP reference.
package turbo_pkg;

   localparam int BLOCK_LEN_DEF = 8;
   localparam int ADDR_W_DEF    = 3;
   localparam int QPP_F1_DEF    = 3;
   localparam int QPP_F2_DEF    = 2;

   typedef enum logic [0:0] {
      RD_IDLE   = 1'b0,
      RD_STREAM = 1'b1
   } rd_state_t;

   // Closed-form pi(k) = (f1*k + f2*k*k) mod n, used to cross-check the
   // incremental generator.
   function automatic int unsigned qpp_ref(input int unsigned k,
                                           input int unsigned n,
                                           input int unsigned f1,
                                           input int unsigned f2);
      return (f1 * k + f2 * k * k) % n;
   endfunction

endpackage

// File: rtl/qpp_index_gen.sv
// Incremental QPP index generator. pi(k+1) = pi(k) + delta(k) and
// delta(k+1) = delta(k) + 2*F2, all modulo 2^ADDR_W, so no multiplier is needed.
// start re-seeds pi = 0, delta = F1+F2 and has priority over step.
module qpp_index_gen
   import turbo_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int QPP_F1 = QPP_F1_DEF,
   parameter int QPP_F2 = QPP_F2_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              step,
   output logic [ADDR_W-1:0] pi
);

   localparam logic [ADDR_W-1:0] DELTA_INIT = ADDR_W'(QPP_F1 + QPP_F2);
   localparam logic [ADDR_W-1:0] DELTA_STEP = ADDR_W'(2 * QPP_F2);

   logic [ADDR_W-1:0] pi_r;
   logic [ADDR_W-1:0] delta_r;

   // Advance the index by the running delta, or re-seed at block start.
   always_ff @(posedge clk) begin
      if (reset || start) begin
         pi_r    <= {ADDR_W{1'b0}};
         delta_r <= DELTA_INIT;
      end else if (step) begin
         pi_r    <= pi_r + delta_r;
         delta_r <= delta_r + DELTA_STEP;
      end else begin
         pi_r    <= pi_r;
         delta_r <= delta_r;
      end
   end

   assign pi = pi_r;

endmodule

// File: rtl/turbo_block_interleaver.sv
// Turbo encoder input stage: collects a serial bit stream into ping-pong blocks
// and replays each completed block as (natural-order, QPP-interleaved) pairs.
// Writing block n+1 overlaps reading block n.
// Optional macro TURBO_ILV_FLUSH_EN adds a 'flush' input that discards the
// partially written block (complete blocks and the reader are untouched).
module turbo_block_interleaver
   import turbo_pkg::*;
#(
   parameter int BLOCK_LEN = BLOCK_LEN_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int QPP_F1    = QPP_F1_DEF,
   parameter int QPP_F2    = QPP_F2_DEF
)(
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic in_data,
   output logic in_ready,
   output logic out_valid,
   input  logic out_ready,
   output logic out_sys,
   output logic out_int,
   output logic out_first,
`ifdef TURBO_ILV_FLUSH_EN
   input  logic flush,
`endif
   output logic out_last
);

   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(BLOCK_LEN - 1);
   localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};

   logic [BLOCK_LEN-1:0] bank_r [2];   // contents are never reset
   logic [1:0]           full_r;
   logic [1:0]           full_set_s;
   logic [1:0]           full_clr_s;

   logic                 wr_bank_r;
   logic [ADDR_W-1:0]    wr_idx_r;
   logic                 rd_bank_r;
   logic [ADDR_W-1:0]    k_r;
   rd_state_t            rd_state_r;
   logic [ADDR_W-1:0]    pi_s;

   logic                 flush_s;
   logic                 wr_fire_s;
   logic                 wr_done_s;
   logic                 valid_s;
   logic                 rd_fire_s;
   logic                 rd_done_s;
   logic                 qpp_start_s;

`ifdef TURBO_ILV_FLUSH_EN
   assign flush_s = flush;
`else
   assign flush_s = 1'b0;
`endif

   // A flush on the same edge as a write wins: the bit is not stored.
   assign in_ready    = ~full_r[wr_bank_r];
   assign wr_fire_s   = in_valid & in_ready & ~flush_s;
   assign wr_done_s   = wr_fire_s & (wr_idx_r == IDX_LAST);

   assign valid_s     = (rd_state_r == RD_STREAM);
   assign rd_fire_s   = valid_s & out_ready;
   assign rd_done_s   = rd_fire_s & (k_r == IDX_LAST);

   // The index generator is held at its seed while idle and re-seeded on the
   // final handshake so a back-to-back block starts at pi(0).
   assign qpp_start_s = ~valid_s | rd_done_s;

   // Store the accepted bit into the bank being filled.
   always_ff @(posedge clk) begin
      if (!reset && wr_fire_s) begin
         bank_r[wr_bank_r][wr_idx_r] <= in_data;
      end
   end

   // Write pointer: advance per accepted bit, hop banks when a block completes.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_bank_r <= 1'b0;
         wr_idx_r  <= IDX_ZERO;
      end else if (flush_s) begin
         wr_idx_r  <= IDX_ZERO;
      end else if (wr_fire_s) begin
         if (wr_idx_r == IDX_LAST) begin
            wr_idx_r  <= IDX_ZERO;
            wr_bank_r <= ~wr_bank_r;
         end else begin
            wr_idx_r  <= wr_idx_r + IDX_ONE;
         end
      end
   end

   // Per-bank set (writer completes) and clear (reader releases) requests;
   // the two always target different banks.
   always_comb begin
      full_set_s = 2'b00;
      full_clr_s = 2'b00;
      if (wr_done_s) begin
         full_set_s[wr_bank_r] = 1'b1;
      end else begin
         full_set_s = 2'b00;
      end
      if (rd_done_s) begin
         full_clr_s[rd_bank_r] = 1'b1;
      end else begin
         full_clr_s = 2'b00;
      end
   end

   // Bank-full flags shared between writer and reader.
   always_ff @(posedge clk) begin
      if (reset) begin
         full_r <= 2'b00;
      end else begin
         full_r <= (full_r | full_set_s) & ~full_clr_s;
      end
   end

   // Read FSM: wait for a full bank, then stream k = 0..BLOCK_LEN-1 under
   // out_ready backpressure; chain straight into the other bank if it is full.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_state_r <= RD_IDLE;
         rd_bank_r  <= 1'b0;
         k_r        <= IDX_ZERO;
      end else begin
         case (rd_state_r)
            RD_IDLE: begin
               k_r <= IDX_ZERO;
               if (full_r[rd_bank_r]) begin
                  rd_state_r <= RD_STREAM;
               end
            end
            RD_STREAM: begin
               if (rd_fire_s) begin
                  if (k_r == IDX_LAST) begin
                     k_r        <= IDX_ZERO;
                     rd_bank_r  <= ~rd_bank_r;
                     rd_state_r <= full_r[~rd_bank_r] ? RD_STREAM : RD_IDLE;
                  end else begin
                     k_r <= k_r + IDX_ONE;
                  end
               end
            end
            default: begin
               rd_state_r <= RD_IDLE;
               k_r        <= IDX_ZERO;
            end
         endcase
      end
   end

   qpp_index_gen #(
      .ADDR_W (ADDR_W),
      .QPP_F1 (QPP_F1),
      .QPP_F2 (QPP_F2)
   ) u_qpp (
      .clk   (clk),
      .reset (reset),
      .start (qpp_start_s),
      .step  (rd_fire_s),
      .pi    (pi_s)
   );

   // Outputs are decoded from state registers only, so they hold during stalls.
   assign out_valid = valid_s;
   assign out_sys   = valid_s & bank_r[rd_bank_r][k_r];
   assign out_int   = valid_s & bank_r[rd_bank_r][pi_s];
   assign out_first = valid_s & (k_r == IDX_ZERO);
   assign out_last  = valid_s & (k_r == IDX_LAST);

endmodule
